// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-K counter controller.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Largest count value for a latched modulus; a modulus of 0 selects the full n-bit range.
  function automatic logic [31:0] keff_m1(input logic [31:0] mk, input int unsigned n);
    logic [31:0] full;
    full = 32'hFFFF_FFFF >> (32 - n);
    if (mk == 32'd0) begin
      keff_m1 = full;
    end else begin
      keff_m1 = mk - 32'd1;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/counter_mod_k_ctrl.sv
// Modulo-K up/down counter with start/load control, one-shot or wrapping operation,
// and a saturating count of wraps since the last start.
module counter_mod_k_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_start,
  input  logic         i_en,
  input  logic         i_up,
  input  logic         i_oneshot,
  input  logic [N-1:0] i_k,
  input  logic         i_load,
  input  logic [N-1:0] i_load_val,
  output logic [N-1:0] o_count,
  output logic         o_tc,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_wraps
);

  state_e       state_q;
  state_e       state_d;
  logic [N-1:0] count_q;
  logic [N-1:0] count_d;
  logic [N-1:0] mk_q;
  logic [N-1:0] mk_d;

  logic [N-1:0] top_cur;
  logic [N-1:0] top_new;
  logic [N-1:0] load_clamped;
  logic         terminal;
  logic         wrap_clear;
  logic         wrap_inc;

  // top_cur bounds the running modulus; top_new is the bound a start would latch.
  assign top_cur      = N'(keff_m1(32'(mk_q), N));
  assign top_new      = N'(keff_m1(32'(i_k), N));
  assign load_clamped = (i_load_val > top_cur) ? top_cur : i_load_val;
  assign terminal     = i_up ? (count_q == top_cur) : (count_q == '0);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mk_d       = mk_q;
    wrap_clear = 1'b0;
    wrap_inc   = 1'b0;

    if (i_start) begin
      state_d    = RUN;
      mk_d       = i_k;
      count_d    = i_up ? '0 : top_new;
      wrap_clear = 1'b1;
    end else if (i_load) begin
      count_d = load_clamped;
    end else begin
      case (state_q)
        RUN: begin
          if (i_en) begin
            if (!terminal) begin
              count_d = i_up ? (count_q + N'(1)) : (count_q - N'(1));
            end else if (i_oneshot) begin
              state_d = DONE;
            end else begin
              count_d  = i_up ? '0 : top_cur;
              wrap_inc = 1'b1;
            end
          end
        end
        IDLE, DONE: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      mk_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mk_q    <= mk_d;
    end
  end

  sat_counter #(
    .W (W)
  ) u_wraps (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .clear   (wrap_clear),
    .inc     (wrap_inc),
    .value   (o_wraps)
  );

  assign o_count = count_q;
  assign o_tc    = (state_q == RUN) && i_en && terminal;
  assign o_busy  = (state_q == RUN);
  assign o_done  = (state_q == DONE);

endmodule

// File: tb/tb_counter_mod_k_ctrl.sv
// Randomized and directed bench for counter_mod_k_ctrl against a behavioural model.
module tb_counter_mod_k_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         oneshot = 1'b0;
  logic [N-1:0] k = '0;
  logic         load = 1'b0;
  logic [N-1:0] lv = '0;
  logic [N-1:0] cnt_o;
  logic         tc_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] wraps_o;

  int n_tests = 0;
  int n_fail  = 0;

  counter_mod_k_ctrl #(.N(N), .W(W)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_start    (start),
    .i_en       (en),
    .i_up       (up),
    .i_oneshot  (oneshot),
    .i_k        (k),
    .i_load     (load),
    .i_load_val (lv),
    .o_count    (cnt_o),
    .o_tc       (tc_o),
    .o_busy     (busy_o),
    .o_done     (done_o),
    .o_wraps    (wraps_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=idle 1=run 2=done, plain integer arithmetic on the modulus.
  typedef struct packed {
    logic [1:0] st;
    logic [7:0] cnt;
    logic [7:0] mk;
    logic [7:0] wr;
  } mstate_t;

  mstate_t m = '0;

  function automatic int keff(input int mk);
    return (mk == 0) ? (1 << N) : mk;
  endfunction

  function automatic bit is_term(input mstate_t s, input bit u);
    if (u) return int'(s.cnt) == keff(int'(s.mk)) - 1;
    return s.cnt == 8'd0;
  endfunction

  function automatic mstate_t nxt(input mstate_t s);
    mstate_t r;
    int      kf;
    int      c;
    r  = s;
    kf = keff(int'(s.mk));
    if (start) begin
      r.st  = 2'd1;
      r.mk  = 8'(k);
      r.wr  = 8'd0;
      r.cnt = up ? 8'd0 : 8'(keff(int'(k)) - 1);
    end else if (load) begin
      c     = (int'(lv) < kf - 1) ? int'(lv) : kf - 1;
      r.cnt = 8'(c);
    end else if (s.st == 2'd1 && en) begin
      if (!is_term(s, up)) begin
        r.cnt = up ? s.cnt + 8'd1 : s.cnt - 8'd1;
      end else if (oneshot) begin
        r.st = 2'd2;
      end else begin
        r.cnt = up ? 8'd0 : 8'(kf - 1);
        if (s.wr < 8'((1 << W) - 1)) r.wr = s.wr + 8'd1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= nxt(m);
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("model_count", int'(cnt_o), int'(m.cnt));
    check("model_wraps", int'(wraps_o), int'(m.wr));
    check("model_busy", int'(busy_o), int'(m.st == 2'd1));
    check("model_done", int'(done_o), int'(m.st == 2'd2));
    check("model_tc", int'(tc_o), int'((m.st == 2'd1) && en && is_term(m, up)));
  end

  task automatic set_in(input bit s, input bit e, input bit u, input bit os,
                        input int kk, input bit ld, input int lvv);
    start   = s;
    en      = e;
    up      = u;
    oneshot = os;
    k       = N'(kk);
    load    = ld;
    lv      = N'(lvv);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    set_in(0, 1, 1, 0, 5, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", int'(cnt_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_wraps", int'(wraps_o), 0);
    check("rst_tc", int'(tc_o), 0);
    rst_n = 1'b1;
    set_in(0, 1, 1, 0, 5, 0, 0);
    tick();
    check("idle_ignores_en", int'(cnt_o), 0);

    // k=5 continuous up
    set_in(1, 0, 1, 0, 5, 0, 0);
    tick();
    for (int i = 0; i < 15; i++) begin
      set_in(0, 1, 1, 0, 5, 0, 0);
      check("k5_count", int'(cnt_o), i % 5);
      check("k5_tc", int'(tc_o), int'(i % 5 == 4));
      tick();
    end
    check("k5_wraps", int'(wraps_o), 3);
    check("k5_count_end", int'(cnt_o), 0);

    // k=3 one-shot down
    set_in(1, 0, 0, 1, 3, 0, 0);
    tick();
    check("k3_start_count", int'(cnt_o), 2);
    check("k3_busy", int'(busy_o), 1);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 1, 3, 0, 0);
      check("k3_count", int'(cnt_o), 2 - i);
      check("k3_tc", int'(tc_o), int'(i == 2));
      tick();
    end
    check("k3_done", int'(done_o), 1);
    check("k3_hold", int'(cnt_o), 0);
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, 0, 1, 3, 0, 0);
      check("k3_done_tc", int'(tc_o), 0);
      tick();
      check("k3_done_hold", int'(cnt_o), 0);
    end
    set_in(1, 0, 0, 1, 3, 0, 0);
    tick();
    check("k3_restart_busy", int'(busy_o), 1);
    check("k3_restart_count", int'(cnt_o), 2);

    // k=0 full range, loads clamp to K_eff-1
    set_in(1, 0, 1, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 1, 0, 0, 1, 15);
    tick();
    check("k0_load15", int'(cnt_o), 15);
    set_in(0, 1, 1, 0, 0, 0, 0);
    check("k0_tc15", int'(tc_o), 1);
    tick();
    check("k0_wrap", int'(cnt_o), 0);
    check("k0_wraps", int'(wraps_o), 1);
    set_in(1, 0, 1, 0, 6, 0, 0);
    tick();
    set_in(0, 0, 1, 0, 6, 1, 9);
    tick();
    check("k6_load_clamp", int'(cnt_o), 5);
    set_in(0, 1, 1, 0, 2, 0, 0);
    check("k6_tc_after_load", int'(tc_o), 1);
    tick();
    check("k6_ignore_k", int'(cnt_o), 0);

    // wrap saturation, then start beats load
    set_in(1, 0, 1, 0, 6, 0, 0);
    tick();
    repeat (60) begin
      set_in(0, 1, 1, 0, 6, 0, 0);
      tick();
    end
    check("sat_wraps", int'(wraps_o), 3);
    set_in(1, 0, 1, 0, 6, 1, 2);
    tick();
    check("start_load_count", int'(cnt_o), 0);
    check("start_load_wraps", int'(wraps_o), 0);

    // async reset between edges
    set_in(1, 0, 1, 0, 8, 0, 0);
    tick();
    repeat (3) begin
      set_in(0, 1, 1, 0, 8, 0, 0);
      tick();
    end
    set_in(0, 0, 1, 0, 8, 0, 0);
    check("pre_reset_count", int'(cnt_o), 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", int'(cnt_o), 0);
    check("async_rst_busy", int'(busy_o), 0);
    #2 rst_n = 1'b1;
    repeat (3) begin
      set_in(0, 1, 1, 0, 8, 0, 0);
      tick();
      check("post_rst_count", int'(cnt_o), 0);
      check("post_rst_busy", int'(busy_o), 0);
    end

    // k=1: constant zero, tc every enabled cycle
    set_in(1, 0, 1, 0, 1, 0, 0);
    tick();
    repeat (4) begin
      set_in(0, 1, 1, 0, 1, 0, 0);
      check("k1_count", int'(cnt_o), 0);
      check("k1_tc", int'(tc_o), 1);
      tick();
    end
    check("k1_wraps", int'(wraps_o), 3);
    set_in(1, 0, 1, 1, 1, 0, 0);
    tick();
    set_in(0, 1, 1, 1, 1, 0, 0);
    check("k1_os_tc", int'(tc_o), 1);
    tick();
    check("k1_os_done", int'(done_o), 1);

    // k=0 down starts at 15
    set_in(1, 0, 0, 0, 0, 0, 0);
    tick();
    check("k0_down_start", int'(cnt_o), 15);
    set_in(0, 1, 0, 0, 0, 0, 0);
    tick();
    check("k0_down_step", int'(cnt_o), 14);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 31) == 0,
             $urandom_range(0, 3) != 0,
             ($urandom_range(0, 15) == 0) ? !up : up,
             ($urandom_range(0, 31) == 0) ? !oneshot : oneshot,
             int'($urandom_range(0, 15)),
             $urandom_range(0, 19) == 0,
             int'($urandom_range(0, 15)));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end

    set_in(0, 0, 1, 0, 0, 0, 0);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
